// File: rtl/writeback_unit_if.sv
// Handshake and register-file write bus between EX/MEM, data memory,
// the writeback unit and the ID-stage register file / bypass network.
interface writeback_unit_if;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  rd_in;
  logic        wb_sel;
  logic [31:0] alu_result;
  logic [2:0]  funct3;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [4:0]  rf_dest;
  logic        rf_write_enable;
  logic [31:0] rf_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        misalign_err;
  logic        timeout_err;

  // Producer side: execute stage and data memory.
  modport master (
    output valid_in, rd_in, wb_sel, alu_result, funct3, mem_rdata, mem_rvalid,
    input  ready_out, rf_dest, rf_write_enable, rf_data,
           fwd_valid, fwd_rd, fwd_data, misalign_err, timeout_err
  );

  // Writeback unit side.
  modport slave (
    input  valid_in, rd_in, wb_sel, alu_result, funct3, mem_rdata, mem_rvalid,
    output ready_out, rf_dest, rf_write_enable, rf_data,
           fwd_valid, fwd_rd, fwd_data, misalign_err, timeout_err
  );
endinterface

// File: rtl/writeback_unit.sv
// Integer register file write side: commits ALU results directly and
// sequences loads (wait for memory, format, commit) with a load watchdog.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a new result, no write this cycle
// WAIT_MEM | load accepted, waiting for mem_rvalid, watchdog running
// COMMIT   | write cycle (suppressed for x0), a new transfer may be taken
module writeback_unit #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int TO_W         = 5
) (
  input  logic              clk,
  input  logic              reset,
  writeback_unit_if.slave   wb
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(LOAD_TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] watchdog;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr;

  logic            xfer;
  logic            ld_legal;
  logic [31:0]     ld_data;

  // A transfer is only possible while ready_out is high (IDLE or COMMIT).
  assign xfer = wb.valid_in & wb.ready_out;

  // Load legality is judged on the incoming request so bad loads never wait on memory.
  always_comb begin
    ld_legal = 1'b0;
    unique case (wb.funct3)
      3'b000, 3'b100: ld_legal = 1'b1;
      3'b001, 3'b101: ld_legal = ~wb.alu_result[0];
      3'b010:         ld_legal = (wb.alu_result[1:0] == 2'b00);
      default:        ld_legal = 1'b0;
    endcase
  end

  // Little-endian byte/half extraction and extension of the returned word.
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    ld_data  = 32'h0000_0000;
    unique case (ld_addr)
      2'd0:    byte_sel = wb.mem_rdata[7:0];
      2'd1:    byte_sel = wb.mem_rdata[15:8];
      2'd2:    byte_sel = wb.mem_rdata[23:16];
      default: byte_sel = wb.mem_rdata[31:24];
    endcase
    half_sel = ld_addr[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
    unique case (ld_funct3)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_data = {24'h000000, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_data = {16'h0000, half_sel};
      default: ld_data = wb.mem_rdata;
    endcase
  end

  // Main sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      watchdog           <= '0;
      ld_rd              <= 5'd0;
      ld_funct3          <= 3'd0;
      ld_addr            <= 2'd0;
      wb.ready_out       <= 1'b1;
      wb.rf_dest         <= 5'd0;
      wb.rf_write_enable <= 1'b0;
      wb.rf_data         <= 32'h0000_0000;
      wb.misalign_err    <= 1'b0;
      wb.timeout_err     <= 1'b0;
    end else begin
      wb.rf_write_enable <= 1'b0;
      wb.misalign_err    <= 1'b0;
      unique case (state)
        S_IDLE, S_COMMIT: begin
          if (xfer && !wb.wb_sel) begin
            // dest/data only move on a real write so they hold otherwise
            state        <= S_COMMIT;
            wb.ready_out <= 1'b1;
            if (wb.rd_in != 5'd0) begin
              wb.rf_write_enable <= 1'b1;
              wb.rf_dest         <= wb.rd_in;
              wb.rf_data         <= wb.alu_result;
            end
          end else if (xfer && ld_legal) begin
            state        <= S_WAIT_MEM;
            wb.ready_out <= 1'b0;
            watchdog     <= '0;
            ld_rd        <= wb.rd_in;
            ld_funct3    <= wb.funct3;
            ld_addr      <= wb.alu_result[1:0];
          end else if (xfer) begin
            state           <= S_IDLE;
            wb.ready_out    <= 1'b1;
            wb.misalign_err <= 1'b1;
          end else begin
            state        <= S_IDLE;
            wb.ready_out <= 1'b1;
          end
        end
        S_WAIT_MEM: begin
          if (wb.mem_rvalid) begin
            state        <= S_COMMIT;
            wb.ready_out <= 1'b1;
            if (ld_rd != 5'd0) begin
              wb.rf_write_enable <= 1'b1;
              wb.rf_dest         <= ld_rd;
              wb.rf_data         <= ld_data;
            end
          end else if (watchdog == WD_LAST) begin
            // load is abandoned; the flag stays up until reset
            state          <= S_IDLE;
            wb.ready_out   <= 1'b1;
            wb.timeout_err <= 1'b1;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          wb.ready_out <= 1'b1;
        end
      endcase
    end
  end

  // Decode bypass mirrors the register file write port.
  assign wb.fwd_valid = wb.rf_write_enable;
  assign wb.fwd_rd    = wb.rf_dest;
  assign wb.fwd_data  = wb.rf_data;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed plus randomized bench for writeback_unit with a behavioural
// model of the expected register-file writes.
module tb_writeback_unit;
  localparam int LOAD_TIMEOUT = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  logic [4:0]  exp_dest;
  logic [31:0] exp_data;
  logic        exp_to;

  writeback_unit_if wif ();

  writeback_unit #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .TO_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Compare every output against the model; we/ready/mis are the per-cycle expectations.
  task automatic chk_all(input string tag, input logic we, input logic rdy, input logic mis);
    chk1 ({tag, ".we"},    wif.rf_write_enable, we);
    chk1 ({tag, ".ready"}, wif.ready_out, rdy);
    chk1 ({tag, ".mis"},   wif.misalign_err, mis);
    chk1 ({tag, ".to"},    wif.timeout_err, exp_to);
    chk32({tag, ".dest"},  32'(wif.rf_dest), 32'(exp_dest));
    chk32({tag, ".data"},  wif.rf_data, exp_data);
    chk1 ({tag, ".fv"},    wif.fwd_valid, we);
    chk32({tag, ".frd"},   32'(wif.fwd_rd), 32'(exp_dest));
    chk32({tag, ".fdata"}, wif.fwd_data, exp_data);
  endtask

  // Reference load semantics: returns {legal, formatted value}.
  function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    int unsigned ai;
    int unsigned b;
    int unsigned h;
    logic [31:0] r;
    ai = 32'(a);
    b  = (w >> (8 * ai)) % 256;
    h  = (w >> (16 * (ai / 2))) % 65536;
    case (f3)
      3'd0:    begin r = (b >= 128) ? b - 32'd256 : b;     return {1'b1, r}; end
      3'd4:    return {1'b1, b};
      3'd1:    begin r = (h >= 32768) ? h - 32'd65536 : h; return {(ai % 2) == 0, r}; end
      3'd5:    return {(ai % 2) == 0, h};
      3'd2:    return {ai == 0, w};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  // Idle cycles; stray mem_rvalid must be ignored and outputs must hold.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      wif.valid_in   = 1'b0;
      wif.mem_rvalid = 1'($urandom_range(0, 1));
      wif.mem_rdata  = $urandom;
      @(negedge clk);
      chk_all("idle", 1'b0, 1'b1, 1'b0);
    end
    wif.mem_rvalid = 1'b0;
  endtask

  // ALU transfer starting at a negedge; write expected on the next edge.
  task automatic alu_xfer(input logic [4:0] rd, input logic [31:0] val);
    wif.valid_in   = 1'b1;
    wif.wb_sel     = 1'b0;
    wif.rd_in      = rd;
    wif.alu_result = val;
    wif.funct3     = 3'($urandom);
    @(negedge clk);
    wif.valid_in = 1'b0;
    if (rd != 5'd0) begin
      exp_dest = rd;
      exp_data = val;
    end
    chk_all("alu", rd != 5'd0, 1'b1, 1'b0);
  endtask

  // Load transfer, nwait cycles of memory latency, then the data word.
  task automatic load_xfer(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                           input logic [31:0] word, input int nwait);
    logic [32:0] r;
    r = ref_load(f3, a, word);
    wif.valid_in   = 1'b1;
    wif.wb_sel     = 1'b1;
    wif.rd_in      = rd;
    wif.funct3     = f3;
    wif.alu_result = {30'($urandom), a};
    @(negedge clk);
    wif.valid_in = 1'b0;
    if (!r[32]) begin
      chk_all("ld_bad", 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk_all("ld_bad_after", 1'b0, 1'b1, 1'b0);
      return;
    end
    chk_all("ld_acc", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nwait; i++) begin
      wif.mem_rvalid = 1'b0;
      wif.mem_rdata  = $urandom;
      @(negedge clk);
      chk_all("ld_wait", 1'b0, 1'b0, 1'b0);
    end
    wif.mem_rvalid = 1'b1;
    wif.mem_rdata  = word;
    @(negedge clk);
    wif.mem_rvalid = 1'b0;
    if (rd != 5'd0) begin
      exp_dest = rd;
      exp_data = r[31:0];
    end
    chk_all("ld_commit", rd != 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    exp_dest = 5'd0;
    exp_data = 32'h0;
    exp_to   = 1'b0;
    reset          = 1'b1;
    wif.valid_in   = 1'b0;
    wif.rd_in      = 5'd0;
    wif.wb_sel     = 1'b0;
    wif.alu_result = 32'h0;
    wif.funct3     = 3'd0;
    wif.mem_rdata  = 32'h0;
    wif.mem_rvalid = 1'b0;

    // reset state
    @(negedge clk);
    chk_all("reset", 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    idle(2);

    // single ALU write with bypass
    alu_xfer(5'd5, 32'h1234_5678);
    idle(1);

    // back-to-back ALU writes
    alu_xfer(5'd3, 32'h0000_000A);
    alu_xfer(5'd4, 32'h0000_000B);
    idle(1);

    // LB / LBU from byte 2 after a 3-cycle wait
    load_xfer(5'd6, 3'b000, 2'd2, 32'h0080_0000, 3);
    chk32("lb_val", wif.rf_data, 32'hFFFF_FF80);
    load_xfer(5'd7, 3'b100, 2'd2, 32'h0080_0000, 3);
    chk32("lbu_val", wif.rf_data, 32'h0000_0080);
    idle(1);

    // misaligned LH, LW to x0, illegal code
    load_xfer(5'd8, 3'b001, 2'd1, 32'h1111_2222, 0);
    load_xfer(5'd0, 3'b010, 2'd0, 32'hDEAD_BEEF, 2);
    idle(1);
    load_xfer(5'd9, 3'b011, 2'd0, 32'h1234_5678, 0);
    load_xfer(5'd9, 3'b010, 2'd2, 32'h1234_5678, 0);
    idle(1);

    // watchdog: no mem_rvalid ever
    wif.valid_in   = 1'b1;
    wif.wb_sel     = 1'b1;
    wif.rd_in      = 5'd10;
    wif.funct3     = 3'b010;
    wif.alu_result = 32'h0000_1000;
    @(negedge clk);
    wif.valid_in = 1'b0;
    for (int k = 1; k <= LOAD_TIMEOUT; k++) begin
      @(negedge clk);
      if (k == LOAD_TIMEOUT) exp_to = 1'b1;
      chk_all($sformatf("to_c%0d", k), 1'b0, k == LOAD_TIMEOUT, 1'b0);
    end
    idle(1);
    alu_xfer(5'd11, 32'hCAFE_F00D);
    idle(1);

    // async reset mid-wait, late mem_rvalid must not write
    wif.valid_in   = 1'b1;
    wif.wb_sel     = 1'b1;
    wif.rd_in      = 5'd12;
    wif.funct3     = 3'b010;
    wif.alu_result = 32'h0;
    @(negedge clk);
    wif.valid_in = 1'b0;
    @(negedge clk);
    chk_all("rst_pre", 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    exp_to   = 1'b0;
    exp_dest = 5'd0;
    exp_data = 32'h0;
    #1 chk_all("rst_mid", 1'b0, 1'b1, 1'b0);
    #1 reset = 1'b0;
    @(negedge clk);
    wif.mem_rvalid = 1'b1;
    wif.mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    wif.mem_rvalid = 1'b0;
    chk_all("rst_post", 1'b0, 1'b1, 1'b0);
    alu_xfer(5'd13, 32'h0BAD_F00D);

    // randomized mix
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0)
        alu_xfer(5'($urandom), $urandom);
      else
        load_xfer(5'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end
endmodule
